// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: decode redirect/exception inputs, combinational ROM port, IF/ID outputs.
// master = fetch stage, slave = decode/ROM side.
interface instr_fetch_if;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        exc;
    logic        irq;
    logic [30:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_id;
    logic [31:0] pc_id_plus4;
    logic [31:0] epc;
    logic        epc_we;

    modport master (
        input  stall, br_taken, br_target, jump, jump_index, jr, jr_target, exc, irq, rom_data,
        output rom_addr, instr, instr_valid, pc_id, pc_id_plus4, epc, epc_we
    );

    modport slave (
        output stall, br_taken, br_target, jump, jump_index, jr, jr_target, exc, irq, rom_data,
        input  rom_addr, instr, instr_valid, pc_id, pc_id_plus4, epc, epc_we
    );
endinterface

// File: rtl/instr_fetch.sv
// MIPS fetch stage: PC with kernel bit, IF/ID register, redirects and irq/exception vectoring.
// Latency one cycle address-to-IR, one bubble per redirect; stall freezes all state. Optional: FETCH_IRQ_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0008,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] epc_q, epc_d;
    logic        valid_q, valid_d;
    logic        epc_we_q, epc_we_d;

    logic [31:0] pc_plus4, pc_id_plus4, jump_tgt, br_tgt, flow_tgt;
    logic        flow_redir, irq_take;

    // Low 31 bits wrap on their own; the kernel bit never takes a carry.
    assign pc_plus4    = {pc_q[31], pc_q[30:0] + 31'd4};
    assign pc_id_plus4 = {pc_id_q[31], pc_id_q[30:0] + 31'd4};
    assign jump_tgt    = {pc_id_q[31], pc_id_plus4[30:28], bus.jump_index, 2'b00};
    assign br_tgt      = {pc_q[31], bus.br_target[30:0]};
    assign flow_redir  = bus.jr | bus.jump | bus.br_taken;

    logic unused_bits;
    assign unused_bits = bus.br_target[31];

`ifdef FETCH_IRQ_EN
    assign irq_take = bus.irq & ~pc_q[31] & ~bus.exc;
`else
    logic unused_irq;
    assign unused_irq = ^{bus.irq, IRQ_VEC};
    assign irq_take   = 1'b0;
`endif

    always_comb begin
        flow_tgt = pc_q;
        if (bus.jr)            flow_tgt = bus.jr_target;
        else if (bus.jump)     flow_tgt = jump_tgt;
        else if (bus.br_taken) flow_tgt = br_tgt;
    end

    always_comb begin
        pc_d     = pc_plus4;
        instr_d  = bus.rom_data;
        pc_id_d  = pc_q;
        valid_d  = 1'b1;
        epc_d    = epc_q;
        epc_we_d = 1'b0;
        if (bus.exc) begin
            pc_d     = EXC_VEC;
            instr_d  = NOP_WORD;
            pc_id_d  = pc_id_q;
            valid_d  = 1'b0;
            epc_d    = pc_id_plus4;
            epc_we_d = 1'b1;
        end else if (irq_take) begin
            // Return address is wherever fetch would have gone had the irq not won.
            pc_d     = IRQ_VEC;
            instr_d  = NOP_WORD;
            pc_id_d  = pc_id_q;
            valid_d  = 1'b0;
            epc_d    = flow_tgt;
            epc_we_d = 1'b1;
        end else if (flow_redir) begin
            pc_d     = flow_tgt;
            instr_d  = NOP_WORD;
            pc_id_d  = pc_id_q;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_WORD;
            pc_id_q  <= 32'h0;
            valid_q  <= 1'b0;
            epc_q    <= 32'h0;
            epc_we_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_id_q  <= pc_id_d;
            valid_q  <= valid_d;
            epc_q    <= epc_d;
            epc_we_q <= epc_we_d;
        end else begin
            epc_we_q <= 1'b0;
        end
    end

    assign bus.rom_addr    = pc_q[30:0];
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_id       = pc_id_q;
    assign bus.pc_id_plus4 = pc_id_plus4;
    assign bus.epc         = epc_q;
    assign bus.epc_we      = epc_we_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; expectations follow whether FETCH_IRQ_EN is defined.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    instr_fetch_if ifc ();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [30:0] a);
        if (a == 31'h0) return 32'h0800_000C;
        return {8'hA0, a[23:0]};
    endfunction

    assign ifc.rom_data = rom_word(ifc.rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ifc.stall      = 1'b0;
        ifc.br_taken   = 1'b0;
        ifc.br_target  = 32'h0;
        ifc.jump       = 1'b0;
        ifc.jump_index = 26'h0;
        ifc.jr         = 1'b0;
        ifc.jr_target  = 32'h0;
        ifc.exc        = 1'b0;
        ifc.irq        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_rom_addr", {1'b0, ifc.rom_addr}, 32'h0);
        chk("rst_instr", ifc.instr, 32'h0);
        chk("rst_valid", {31'h0, ifc.instr_valid}, 32'h0);
        chk("rst_pc_id", ifc.pc_id, 32'h0);
        chk("rst_pc_id_p4", ifc.pc_id_plus4, 32'h4);
        chk("rst_epc", ifc.epc, 32'h0);
        chk("rst_epc_we", {31'h0, ifc.epc_we}, 32'h0);

        reset = 1'b0;
        tick();
        chk("w0_instr", ifc.instr, 32'h0800_000C);
        chk("w0_pc_id", ifc.pc_id, 32'h8000_0000);
        chk("w0_valid", {31'h0, ifc.instr_valid}, 32'h1);
        chk("w0_rom_addr", {1'b0, ifc.rom_addr}, 32'h4);

        // jump to index 0xC from kernel word 0
        ifc.jump = 1'b1; ifc.jump_index = 26'h00000C;
        tick();
        chk("j_bubble_valid", {31'h0, ifc.instr_valid}, 32'h0);
        chk("j_bubble_instr", ifc.instr, 32'h0);
        chk("j_rom_addr", {1'b0, ifc.rom_addr}, 32'h30);
        clr();
        tick();
        chk("j_pc_id", ifc.pc_id, 32'h8000_0030);
        chk("j_instr", ifc.instr, 32'hA000_0030);
        chk("j_valid", {31'h0, ifc.instr_valid}, 32'h1);

        // jr into user code at 0x50, then irq
        ifc.jr = 1'b1; ifc.jr_target = 32'h0000_0050;
        tick();
        chk("jr_rom_addr", {1'b0, ifc.rom_addr}, 32'h50);
        chk("jr_valid", {31'h0, ifc.instr_valid}, 32'h0);
        clr();
        ifc.irq = 1'b1;
        tick();
`ifdef FETCH_IRQ_EN
        chk("irq_rom_addr", {1'b0, ifc.rom_addr}, 32'h4);
        chk("irq_epc", ifc.epc, 32'h50);
        chk("irq_epc_we", {31'h0, ifc.epc_we}, 32'h1);
        chk("irq_valid", {31'h0, ifc.instr_valid}, 32'h0);
        tick();
        chk("irqk_rom_addr", {1'b0, ifc.rom_addr}, 32'h8);
        chk("irqk_epc_we", {31'h0, ifc.epc_we}, 32'h0);
        chk("irqk_epc", ifc.epc, 32'h50);
        chk("irqk_pc_id", ifc.pc_id, 32'h8000_0004);
`else
        chk("irqoff_rom_addr", {1'b0, ifc.rom_addr}, 32'h54);
        chk("irqoff_epc_we", {31'h0, ifc.epc_we}, 32'h0);
        chk("irqoff_pc_id", ifc.pc_id, 32'h50);
        tick();
        chk("irqoff_rom_addr2", {1'b0, ifc.rom_addr}, 32'h58);
        chk("irqoff_epc", ifc.epc, 32'h0);
`endif

        // jr back to user with irq still high
        ifc.jr = 1'b1; ifc.jr_target = 32'h0000_0050;
        tick();
        chk("jr2_rom_addr", {1'b0, ifc.rom_addr}, 32'h50);
        ifc.jr = 1'b0;
        tick();
`ifdef FETCH_IRQ_EN
        chk("irq2_rom_addr", {1'b0, ifc.rom_addr}, 32'h4);
        chk("irq2_epc_we", {31'h0, ifc.epc_we}, 32'h1);
        chk("irq2_epc", ifc.epc, 32'h50);
`else
        chk("irq2off_rom_addr", {1'b0, ifc.rom_addr}, 32'h54);
        chk("irq2off_pc_id", ifc.pc_id, 32'h50);
        chk("irq2off_epc_we", {31'h0, ifc.epc_we}, 32'h0);
`endif
        clr();

        // exc with pc_id=0x40 and irq in the same cycle
        ifc.jr = 1'b1; ifc.jr_target = 32'h0000_0040;
        tick();
        clr();
        tick();
        chk("pre_exc_pc_id", ifc.pc_id, 32'h40);
        ifc.exc = 1'b1; ifc.irq = 1'b1;
        tick();
        chk("exc_rom_addr", {1'b0, ifc.rom_addr}, 32'h8);
        chk("exc_epc", ifc.epc, 32'h44);
        chk("exc_epc_we", {31'h0, ifc.epc_we}, 32'h1);
        chk("exc_valid", {31'h0, ifc.instr_valid}, 32'h0);

        // stall with a branch pending: nothing moves, strobe drops
        clr();
        ifc.stall = 1'b1; ifc.br_taken = 1'b1; ifc.br_target = 32'h0000_0020;
        tick();
        chk("stl_epc_we", {31'h0, ifc.epc_we}, 32'h0);
        chk("stl_rom_addr", {1'b0, ifc.rom_addr}, 32'h8);
        chk("stl_epc", ifc.epc, 32'h44);
        chk("stl_pc_id", ifc.pc_id, 32'h40);
        chk("stl_valid", {31'h0, ifc.instr_valid}, 32'h0);
        tick();
        chk("stl2_rom_addr", {1'b0, ifc.rom_addr}, 32'h8);
        clr();
        tick();
        chk("unstl_rom_addr", {1'b0, ifc.rom_addr}, 32'hC);
        chk("unstl_pc_id", ifc.pc_id, 32'h8000_0008);
        chk("unstl_instr", ifc.instr, 32'hA000_0008);
        chk("unstl_valid", {31'h0, ifc.instr_valid}, 32'h1);

        // irq together with jump to 0x100 from user code
        ifc.jr = 1'b1; ifc.jr_target = 32'h0000_0060;
        tick();
        clr();
        tick();
        chk("pre_ij_pc_id", ifc.pc_id, 32'h60);
        ifc.jump = 1'b1; ifc.jump_index = 26'h000040; ifc.irq = 1'b1;
        tick();
`ifdef FETCH_IRQ_EN
        chk("ij_rom_addr", {1'b0, ifc.rom_addr}, 32'h4);
        chk("ij_epc", ifc.epc, 32'h100);
        chk("ij_epc_we", {31'h0, ifc.epc_we}, 32'h1);
`else
        chk("ijoff_rom_addr", {1'b0, ifc.rom_addr}, 32'h100);
        chk("ijoff_epc_we", {31'h0, ifc.epc_we}, 32'h0);
        chk("ijoff_epc", ifc.epc, 32'h44);
`endif
        clr();

        // user-mode wrap at the top of the 31-bit space
        ifc.jr = 1'b1; ifc.jr_target = 32'h7FFF_FFFC;
        tick();
        chk("wrapu_rom_addr", {1'b0, ifc.rom_addr}, 32'h7FFF_FFFC);
        clr();
        tick();
        chk("wrapu_rom_addr2", {1'b0, ifc.rom_addr}, 32'h0);
        chk("wrapu_pc_id", ifc.pc_id, 32'h7FFF_FFFC);
        tick();
        chk("wrapu_pc_id2", ifc.pc_id, 32'h0000_0000);
        chk("wrapu_instr", ifc.instr, 32'h0800_000C);

        // kernel-mode wrap keeps the mode bit
        ifc.jr = 1'b1; ifc.jr_target = 32'hFFFF_FFFC;
        tick();
        clr();
        tick();
        chk("wrapk_pc_id", ifc.pc_id, 32'hFFFF_FFFC);
        chk("wrapk_pc_id_p4", ifc.pc_id_plus4, 32'h8000_0000);
        tick();
        chk("wrapk_pc_id2", ifc.pc_id, 32'h8000_0000);

        // reset beats stall and redirect
        ifc.stall = 1'b1; ifc.jr = 1'b1; ifc.jr_target = 32'h0000_0200;
        reset = 1'b1;
        tick();
        chk("rst2_rom_addr", {1'b0, ifc.rom_addr}, 32'h0);
        chk("rst2_valid", {31'h0, ifc.instr_valid}, 32'h0);
        chk("rst2_pc_id", ifc.pc_id, 32'h0);
        chk("rst2_epc", ifc.epc, 32'h0);
        chk("rst2_instr", ifc.instr, 32'h0);
        clr();
        reset = 1'b0;
        tick();
        chk("rst2_w0_pc_id", ifc.pc_id, 32'h8000_0000);
        chk("rst2_w0_instr", ifc.instr, 32'h0800_000C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
